// File: rtl/d_mem_pkg.sv
// -----------------------------------------------------------------------------
// d_mem_pkg
// Shared definitions for the D-format data-memory responder.
//   state_t : responder FSM states (IDLE, WR, RD, RESP)
//   size_t  : request size encoding, matches op[10] (SIZE_B byte, SIZE_D dword)
//   BEATS_D / BEATS_B : RAM beats per doubleword / byte access
//   RD_LAT  : cycles from a RAM read issue to its data on mem_rdata
// -----------------------------------------------------------------------------
package d_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic {
        SIZE_B = 1'b0,
        SIZE_D = 1'b1
    } size_t;

    localparam int BEATS_D = 8;
    localparam int BEATS_B = 1;
    localparam int RD_LAT  = 1;

endpackage

// File: rtl/d_mem_lane_shift.sv
// -----------------------------------------------------------------------------
// d_mem_lane_shift
// 64-bit little-endian byte-lane register shared by stores and loads.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : latch i_wdata (store accepted)
//   i_clear        : clear all lanes (load accepted)
//   i_cap_en       : write i_cap_byte into lane i_cap_idx
//   i_size_d       : 1 = doubleword access, 0 = byte access
//   i_wdata        : store data to latch
//   i_rd_idx       : lane presented on o_byte (store beat index)
//   i_cap_idx      : lane receiving the captured load byte
//   i_cap_byte     : byte returned by RAM
//   o_byte         : store byte for the current beat
//   o_merged       : lanes with the incoming byte already inserted, upper
//                    lanes forced to zero on byte accesses
// -----------------------------------------------------------------------------
module d_mem_lane_shift (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic        i_cap_en,
    input  logic        i_size_d,
    input  logic [63:0] i_wdata,
    input  logic [2:0]  i_rd_idx,
    input  logic [2:0]  i_cap_idx,
    input  logic [7:0]  i_cap_byte,
    output logic [7:0]  o_byte,
    output logic [63:0] o_merged
);

    logic [63:0] r_lanes;

    assign o_byte = r_lanes[{i_rd_idx, 3'b000} +: 8];

    // The merged view lets the top register the final load word in the same
    // edge that captures the last byte, saving a cycle of latency.
    always_comb begin
        o_merged = r_lanes;
        o_merged[{i_cap_idx, 3'b000} +: 8] = i_cap_byte;
        if (!i_size_d) begin
            o_merged[63:8] = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lanes <= '0;
        end else if (i_clear) begin
            r_lanes <= '0;
        end else if (i_load) begin
            r_lanes <= i_wdata;
        end else if (i_cap_en) begin
            r_lanes <= o_merged;
        end
    end

endmodule

// File: rtl/d_mem_responder.sv
// -----------------------------------------------------------------------------
// d_mem_responder
// Serialises one LDUR/STUR-family request onto a byte-wide synchronous RAM,
// little-endian, and returns a single-cycle response.
//   clock, reset         : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_write            : 1 store, 0 load
//   req_size             : 1 doubleword (8 beats), 0 byte (1 beat)
//   req_addr, req_wdata  : byte address (truncated to ADDR_W), store data
//   rsp_valid            : one-cycle completion pulse
//   rsp_rdata            : load data (byte loads zero-extended), held
//   rsp_err              : error flag with rsp_valid
//   mem_en/we/addr/wdata : RAM request port (registered)
//   mem_rdata            : RAM read byte, one cycle after the read issue
// Optional build macro D_MEM_ALIGN_CHECK_EN: misaligned doublewords and
// addresses beyond ADDR_W respond immediately with rsp_err=1 and no RAM
// beats. Without it rsp_err is always 0 and such accesses wrap.
// -----------------------------------------------------------------------------
module d_mem_responder
    import d_mem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_size,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t              r_state;
    size_t               r_size;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [63:0]         r_rsp_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic [3:0]          r_beat;      // next beat index to issue
    logic [2:0]          r_cap;       // next lane to capture on loads
    logic [RD_LAT-1:0]   r_rd_pipe;   // read issues in flight toward mem_rdata

    logic                w_accept;
    logic                w_bad;
    logic [3:0]          w_nbeats;
    logic [2:0]          w_last_cap;
    logic                w_cap_en;
    logic [7:0]          w_lane_byte;
    logic [63:0]         w_merged;

    assign w_accept   = req_valid && r_req_ready;
    assign w_nbeats   = (r_size == SIZE_D) ? 4'(BEATS_D) : 4'(BEATS_B);
    assign w_last_cap = 3'(w_nbeats - 4'd1);
    assign w_cap_en   = (r_state == RD) && r_rd_pipe[RD_LAT-1];

`ifdef D_MEM_ALIGN_CHECK_EN
    assign w_bad = (req_size && (req_addr[2:0] != 3'b000)) ||
                   (req_addr[63:ADDR_W] != '0);
`else
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^req_addr[63:ADDR_W];
    assign w_bad            = 1'b0;
`endif

    d_mem_lane_shift u_lanes (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_accept && req_write),
        .i_clear    (w_accept && !req_write),
        .i_cap_en   (w_cap_en),
        .i_size_d   (r_size == SIZE_D),
        .i_wdata    (req_wdata),
        .i_rd_idx   (r_beat[2:0]),
        .i_cap_idx  (r_cap),
        .i_cap_byte (mem_rdata),
        .o_byte     (w_lane_byte),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_size      <= SIZE_B;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_beat      <= '0;
            r_cap       <= '0;
            r_rd_pipe   <= '0;
        end else begin
            // Track read issues so captures land exactly RD_LAT cycles later.
            r_rd_pipe[0] <= r_mem_en && !r_mem_we;
            for (int i = 1; i < RD_LAT; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_size      <= size_t'(req_size);
                        r_beat      <= 4'd1;
                        r_cap       <= '0;
                        if (w_bad) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            // Beat 0 goes out directly from the request.
                            r_mem_en   <= 1'b1;
                            r_mem_we   <= req_write;
                            r_mem_addr <= req_addr[ADDR_W-1:0];
                            if (req_write) begin
                                r_mem_wdata <= req_wdata[7:0];
                                r_state     <= WR;
                            end else begin
                                r_state     <= RD;
                            end
                        end
                    end
                end

                WR: begin
                    if (r_beat == w_nbeats) begin
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_mem_addr  <= r_mem_addr + 1'b1;
                        r_mem_wdata <= w_lane_byte;
                        r_beat      <= r_beat + 4'd1;
                    end
                end

                RD: begin
                    if (r_beat == w_nbeats) begin
                        r_mem_en <= 1'b0;
                    end else begin
                        r_mem_addr <= r_mem_addr + 1'b1;
                        r_beat     <= r_beat + 4'd1;
                    end
                    if (w_cap_en) begin
                        r_cap <= r_cap + 3'd1;
                        if (r_cap == w_last_cap) begin
                            r_rsp_rdata <= w_merged;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end
                    end
                end

                RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/d_mem_responder.md
Name: d_mem_responder

Overview:
- Data-memory responder for D-format load/store (LDUR/STUR family) control words issued by the control unit.
- Accepts one request (address, store data, load/store, size) over a valid/ready handshake.
- Serialises the request onto a byte-wide synchronous RAM port, little-endian, then returns one response pulse carrying load data.
- Supports both 8-bit and 64-bit accesses, completing the byte-size path the decoder encodes in op[10].

Parameters:
- ADDR_W, 16, width of the byte-address port to RAM; request address is truncated to this width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1=store, 0=load (matches op[1]).
- req_size  in  1  1=64-bit doubleword, 0=8-bit byte (matches op[10]).
- req_addr  in  64  byte address (Rn + K).
- req_wdata  in  64  store data (Rt).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  64  load data, valid with rsp_valid; byte loads zero-extended.
- rsp_err  out  1  error flag, valid with rsp_valid.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  RAM write this cycle.
- mem_addr  out  ADDR_W  RAM byte address.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte, valid the cycle after the mem_en read.

Behaviour:
- Reset (async, active-low):
  - state=IDLE; req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Beat counters=0.
- Handshake:
  - Accept on the clock edge where req_valid&&req_ready; latch all request fields.
  - req_ready is 0 from the cycle after accept until the cycle after rsp_valid; no overlap between requests.
- Beats: N = req_size ? 8 : 1. Beat i uses mem_addr = addr[ADDR_W-1:0]+i, modulo 2^ADDR_W (wraps past top).
- Little-endian: beat i carries byte i, i.e. bits [8i+7:8i].
- States:
  - IDLE -> WR on accepted store; IDLE -> RD on accepted load.
  - WR: mem_en=mem_we=1 and mem_wdata=byte i for N consecutive cycles, then -> RESP.
  - RD: mem_en=1, mem_we=0 for N consecutive issue cycles.
    - Captures are pipelined one cycle behind issues; the byte from beat i is placed in lane i.
    - After the last capture -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
- rsp_rdata:
  - Holds its value until the next load response.
  - Store responses leave rsp_rdata unchanged.
  - Byte load: upper 56 bits are 0.
- Latency, accept at edge T (cycle T+1 is first beat):
  - Byte store: rsp_valid at T+2.
  - Doubleword store: rsp_valid at T+9.
  - Byte load: rsp_valid at T+3.
  - Doubleword load: rsp_valid at T+10.
- mem_en/mem_we outside active beats are 0; mem_addr/mem_wdata hold their last values.
- Reset asserted mid-transaction: abort immediately to reset values, with no response.
  - A partially written doubleword stays partially written in RAM; this is accepted.
- req_addr bits above ADDR_W are ignored (no error) unless the optional feature below is enabled.

Optional Feature:
- Macro: D_MEM_ALIGN_CHECK_EN.
- Defined:
  - A doubleword with req_addr[2:0]!=0, or any request with req_addr[63:ADDR_W]!=0, performs no memory beats.
  - Goes IDLE -> RESP directly, giving rsp_valid at T+1 with rsp_err=1.
  - rsp_rdata is unchanged.
- Undefined: rsp_err is tied 0; misaligned or out-of-range accesses proceed with wrap as above.

Decomposition:
- Shared package d_mem_pkg:
  - State enum: IDLE, WR, RD, RESP.
  - Size encodings: SIZE_B=0, SIZE_D=1.
  - Constants: BEATS_D=8, BEATS_B=1, RD_LAT=1.
- One natural sub-module: d_mem_lane_shift.
  - 64-bit byte-lane register.
  - Presents byte i for writes.
  - Inserts captured byte into lane i for reads.
  - Clears upper lanes on byte loads.

Test Plan:
- Store doubleword 0x0123456789ABCDEF at addr 0x0010 -> mem writes 0xEF@0x10 … 0x01@0x17 on cycles T+1..T+8; rsp_valid at T+9; req_ready=0 during T+1..T+9.
- Load doubleword from 0x0010 after the above -> rsp_rdata=0x0123456789ABCDEF at T+10; exactly one rsp_valid pulse.
- Byte store 0xAA at 0x0005, then byte load from 0x0005 -> rsp_rdata=0x00000000000000AA; rsp_valid at T+2 (store) and T+3 (load).
- Doubleword store at 0xFFFC with ADDR_W=16 -> beats at 0xFFFC..0xFFFF then 0x0000..0x0003; load-back returns identical data.
- Assert reset at beat 4 of a doubleword load -> all outputs zero immediately, no rsp_valid; next request accepted and served normally.
- With D_MEM_ALIGN_CHECK_EN: doubleword load at 0x0013 -> mem_en never asserted; rsp_valid with rsp_err=1 at T+1. Without the macro: normal 8-beat load, rsp_err=0.
